// File: rtl/ahb_ram_subordinate.sv
// AHB-Lite RAM subordinate: single-port word RAM with lane-merged writes,
// optional data-phase wait states and a two-cycle ERROR response.
module ahb_ram_subordinate #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);
  // state   | meaning
  // ST_IDLE | no data phase pending, ready, OKAY
  // ST_WAIT | inserted wait state, counter running down
  // ST_DATA | final data-phase cycle of an OKAY transfer
  // ST_ERR1 | first ERROR cycle, hreadyout low
  // ST_ERR2 | second ERROR cycle, hreadyout high
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  logic [2:0]       state;
  logic [IDX_W-1:0] idx_q;
  logic [1:0]       lane_q;
  logic             write_q;
  logic [2:0]       size_q;
  logic [3:0]       wait_cnt;
  logic [31:0]      mem [MEM_WORDS];

  logic       open_phase;
  logic       accept;
  logic       xfer_err;
  logic [3:0] byte_en;
  logic       unused_ok;

  assign unused_ok = ^{hburst, haddr[31:IDX_W+2]};

  // New address phases are only sampled in states that drive hreadyout high.
  assign open_phase = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
  assign accept     = open_phase & hsel & hready & htrans[1];
  assign xfer_err   = (hsize > 3'b010) ||
                      ((hsize == 3'b001) && haddr[0]) ||
                      ((hsize == 3'b010) && (haddr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= ST_IDLE;
      idx_q    <= '0;
      lane_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= ST_DATA;
        end
        ST_ERR1: state <= ST_ERR2;
        default: begin
          if (accept) begin
            idx_q   <= haddr[IDX_W+1:2];
            lane_q  <= haddr[1:0];
            write_q <= hwrite;
            size_q  <= hsize;
            if (xfer_err) begin
              state <= ST_ERR1;
            end else if (WAIT_STATES == 0) begin
              state <= ST_DATA;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LD;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      3'b000:  byte_en = 4'b0001 << lane_q;
      3'b001:  byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  // Write commits on the edge closing ST_DATA, so a following read sees it.
  always_ff @(posedge clk) begin
    if ((state == ST_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hreadyout = !((state == ST_WAIT) || (state == ST_ERR1));
  assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
  assign hrdata    = ((state == ST_DATA) && !write_q) ? mem[idx_q] : 32'h0;

endmodule

// File: tb/tb_ahb_ram_subordinate.sv
// Bench for ahb_ram_subordinate: two instances (0 and 3 wait states) driven by a
// pipelined AHB master, checked against directed tables and a byte-level RAM model.
module tb_ahb_ram_subordinate;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst;
  logic        hsel_b     [2];
  logic [31:0] haddr_b    [2];
  logic [1:0]  htrans_b   [2];
  logic        hwrite_b   [2];
  logic [2:0]  hsize_b    [2];
  logic [2:0]  hburst_b   [2];
  logic [31:0] hwdata_b   [2];
  logic        hready_b   [2];
  logic        hreadyout_b[2];
  logic        hresp_b    [2];
  logic [31:0] hrdata_b   [2];
  logic        hready_ovr;
  logic        hready_rnd;

  assign hready_b[0] = hready_ovr ? hready_rnd : hreadyout_b[0];
  assign hready_b[1] = hready_ovr ? hready_rnd : hreadyout_b[1];

  ahb_ram_subordinate #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .nrst(nrst), .hsel(hsel_b[0]), .haddr(haddr_b[0]), .htrans(htrans_b[0]),
    .hwrite(hwrite_b[0]), .hsize(hsize_b[0]), .hburst(hburst_b[0]), .hwdata(hwdata_b[0]),
    .hready(hready_b[0]), .hreadyout(hreadyout_b[0]), .hresp(hresp_b[0]), .hrdata(hrdata_b[0])
  );

  ahb_ram_subordinate #(.MEM_WORDS(1024), .WAIT_STATES(3)) dut3 (
    .clk(clk), .nrst(nrst), .hsel(hsel_b[1]), .haddr(haddr_b[1]), .htrans(htrans_b[1]),
    .hwrite(hwrite_b[1]), .hsize(hsize_b[1]), .hburst(hburst_b[1]), .hwdata(hwdata_b[1]),
    .hready(hready_b[1]), .hreadyout(hreadyout_b[1]), .hresp(hresp_b[1]), .hrdata(hrdata_b[1])
  );

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hand;
    logic        exp_err;
    logic [31:0] exp_rd;
  } tx_t;

  localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SZB = 3'b000, SZH = 3'b001, SZW = 3'b010;

  tx_t txq[$];
  int  errors = 0;
  int  checks = 0;
  bit [31:0] mm [2][1024];
  bit [3:0]  mv [2][1024];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : 3;
  endfunction

  function automatic tx_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                             input logic [2:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic exp_err,
                             input logic [31:0] exp_rd);
    tx_t t;
    t.sel = sel; t.trans = trans; t.wr = wr; t.size = size; t.addr = addr;
    t.wdata = wdata; t.hand = 1'b1; t.exp_err = exp_err; t.exp_rd = exp_rd;
    return t;
  endfunction

  function automatic tx_t rnd_tx();
    tx_t t;
    int  r;
    t.sel   = ($urandom_range(0, 9) != 0);
    r       = $urandom_range(0, 9);
    t.trans = (r < 2) ? IDL : (r < 3) ? BSY : (r < 7) ? NSQ : SQ;
    t.wr    = 1'($urandom_range(0, 1));
    t.size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    t.addr  = {20'($urandom), 6'b010000, 4'($urandom), 2'($urandom)};
    if ($urandom_range(0, 3) != 0) begin
      if (t.size == SZH) t.addr[0] = 1'b0;
      if (t.size == SZW) t.addr[1:0] = 2'b00;
    end
    t.wdata = $urandom;
    t.hand = 1'b0; t.exp_err = 1'b0; t.exp_rd = 32'h0;
    return t;
  endfunction

  // Error rule: size wider than a word, or address not a multiple of the size.
  function automatic logic exp_err_of(input tx_t t);
    int nb;
    nb = 1 << t.size;
    if (t.hand) return t.exp_err;
    return (nb > 4) || ((int'(t.addr[1:0]) % nb) != 0);
  endfunction

  task automatic complete(input int s, input tx_t t, input int waits);
    logic        e_err;
    int          nb, lane, wi;
    logic [31:0] m;
    e_err = exp_err_of(t);
    nb    = 1 << t.size;
    lane  = int'(t.addr[1:0]);
    wi    = int'(t.addr[11:2]);
    chk("hresp", 32'(hresp_b[s]), 32'(e_err));
    chk("ready_low_cycles", 32'(waits), 32'(e_err ? 1 : wait_of(s)));
    if (!t.wr) begin
      if (e_err) begin
        chk("hrdata_err", hrdata_b[s], 32'h0);
      end else if (t.hand) begin
        chk("hrdata_dir", hrdata_b[s], t.exp_rd);
      end else begin
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (mv[s][wi][b]) m[8*b +: 8] = 8'hFF;
        if (m != 32'h0) chk("hrdata_rnd", hrdata_b[s] & m, mm[s][wi] & m);
      end
    end else if (!e_err) begin
      for (int b = lane; b < lane + nb; b++) begin
        mm[s][wi][8*b +: 8] = t.wdata[8*b +: 8];
        mv[s][wi][b] = 1'b1;
      end
    end
  endtask

  task automatic drive_addr(input int s, input int k);
    tx_t t;
    if (k < txq.size()) begin
      t = txq[k];
      hsel_b[s] = t.sel; htrans_b[s] = t.trans; hwrite_b[s] = t.wr;
      hsize_b[s] = t.size; haddr_b[s] = t.addr;
    end else begin
      hsel_b[s] = 1'b0; htrans_b[s] = IDL;
    end
    hburst_b[s] = 3'($urandom);
  endtask

  // Pipelined master: address phase k overlaps the data phase of the previous beat.
  task automatic run(input int s);
    tx_t cur;
    bit  cur_v, acc;
    int  k, n, waits;
    n = txq.size(); k = 0; cur_v = 1'b0;
    @(posedge clk); #1;
    drive_addr(s, k);
    while (k < n || cur_v) begin
      waits = 0;
      @(negedge clk);
      while (!hreadyout_b[s] && waits < 40) begin
        if (cur_v) chk("hresp_stall", 32'(hresp_b[s]), 32'(exp_err_of(cur)));
        waits++;
        @(negedge clk);
      end
      if (!hreadyout_b[s]) begin
        chk("ready_timeout", 32'(hreadyout_b[s]), 32'h1);
        txq.delete();
        return;
      end
      if (cur_v) complete(s, cur, waits);
      else chk("idle_ready", 32'(waits), 32'h0);
      acc = (k < n) && txq[k].sel && txq[k].trans[1];
      if (acc) cur = txq[k];
      cur_v = acc;
      if (k < n) k++;
      @(posedge clk); #1;
      drive_addr(s, k);
      hwdata_b[s] = cur_v ? cur.wdata : $urandom;
    end
    txq.delete();
  endtask

  initial begin
    tx_t tab0[16];
    tx_t tab3[6];

    tab0[0]  = mk(1, IDL, 0, SZW, 32'h10, 32'h0,        0, 32'h0);
    tab0[1]  = mk(1, NSQ, 1, SZW, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    tab0[2]  = mk(1, NSQ, 0, SZW, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    tab0[3]  = mk(1, NSQ, 1, SZW, 32'h20, 32'h11223344, 0, 32'h0);
    tab0[4]  = mk(1, SQ,  1, SZB, 32'h21, 32'h0000AA00, 0, 32'h0);
    tab0[5]  = mk(1, SQ,  1, SZH, 32'h22, 32'hBEEF0000, 0, 32'h0);
    tab0[6]  = mk(1, NSQ, 0, SZW, 32'h20, 32'h0,        0, 32'hBEEFAA44);
    tab0[7]  = mk(1, NSQ, 0, SZW, 32'h12, 32'h0,        1, 32'h0);
    tab0[8]  = mk(1, NSQ, 0, SZW, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    tab0[9]  = mk(1, NSQ, 1, SZH, 32'h23, 32'h12345678, 1, 32'h0);
    tab0[10] = mk(1, NSQ, 0, SZH, 32'h22, 32'h0,        0, 32'hBEEFAA44);
    tab0[11] = mk(0, NSQ, 1, SZW, 32'h20, 32'hFFFFFFFF, 0, 32'h0);
    tab0[12] = mk(1, BSY, 1, SZW, 32'h20, 32'hFFFFFFFF, 0, 32'h0);
    tab0[13] = mk(1, NSQ, 0, SZW, 32'h20, 32'h0,        0, 32'hBEEFAA44);
    tab0[14] = mk(1, NSQ, 0, 3'b011, 32'h20, 32'h0,     1, 32'h0);
    tab0[15] = mk(1, SQ,  0, SZB, 32'h23, 32'h0,        0, 32'hBEEFAA44);

    tab3[0] = mk(1, NSQ, 1, SZW, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    tab3[1] = mk(1, NSQ, 0, SZW, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    tab3[2] = mk(1, SQ,  0, SZW, 32'h10, 32'h0,        0, 32'hDEADBEEF);
    tab3[3] = mk(1, NSQ, 0, SZW, 32'h12, 32'h0,        1, 32'h0);
    tab3[4] = mk(1, NSQ, 1, SZB, 32'h13, 32'h55000000, 0, 32'h0);
    tab3[5] = mk(1, NSQ, 0, SZW, 32'h10, 32'h0,        0, 32'h55ADBEEF);

    nrst = 1'b0;
    hready_ovr = 1'b1;
    hready_rnd = 1'b1;
    for (int s = 0; s < 2; s++) begin
      hsel_b[s] = 1'b0; haddr_b[s] = 32'h0; htrans_b[s] = IDL; hwrite_b[s] = 1'b0;
      hsize_b[s] = SZW; hburst_b[s] = 3'b000; hwdata_b[s] = 32'h0;
    end

    // Reset held with random bus activity
    repeat (6) begin
      @(posedge clk); #1;
      hready_rnd = 1'($urandom);
      for (int s = 0; s < 2; s++) begin
        hsel_b[s] = 1'($urandom); haddr_b[s] = $urandom; htrans_b[s] = 2'($urandom);
        hwrite_b[s] = 1'($urandom); hsize_b[s] = 3'($urandom); hwdata_b[s] = $urandom;
      end
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("rst_hreadyout", 32'(hreadyout_b[s]), 32'h1);
        chk("rst_hresp", 32'(hresp_b[s]), 32'h0);
        chk("rst_hrdata", hrdata_b[s], 32'h0);
      end
    end
    for (int s = 0; s < 2; s++) begin
      hsel_b[s] = 1'b0; htrans_b[s] = IDL;
    end
    hready_ovr = 1'b0;
    nrst = 1'b1;

    for (int i = 0; i < 16; i++) txq.push_back(tab0[i]);
    run(0);
    for (int i = 0; i < 6; i++) txq.push_back(tab3[i]);
    run(1);

    // Reset asserted while a write is stalled in a wait state
    txq.push_back(mk(1, NSQ, 1, SZW, 32'h40, 32'h12345678, 0, 32'h0));
    run(1);
    hsel_b[1] = 1'b1; htrans_b[1] = NSQ; hwrite_b[1] = 1'b1; hsize_b[1] = SZW; haddr_b[1] = 32'h40;
    @(posedge clk); #1;
    hsel_b[1] = 1'b0; htrans_b[1] = IDL; hwdata_b[1] = 32'hCAFEF00D;
    @(negedge clk);
    chk("stall_before_rst", 32'(hreadyout_b[1]), 32'h0);
    #1 nrst = 1'b0;
    #1;
    chk("midrst_hreadyout", 32'(hreadyout_b[1]), 32'h1);
    chk("midrst_hresp", 32'(hresp_b[1]), 32'h0);
    chk("midrst_hrdata", hrdata_b[1], 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    txq.push_back(mk(1, NSQ, 0, SZW, 32'h40, 32'h0, 0, 32'h12345678));
    run(1);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 200; i++) txq.push_back(rnd_tx());
      run(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
